// File: rtl/execute_md_stage.sv
// Pipeline E stage: forwarding, ALU, result select, hazard outputs,
// plus a multi-cycle multiply/divide unit with HI/LO and D-stage stall.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   instr_e, pc_e       instruction in E and its PC
//   write_reg_e         destination register decided in D
//   rd1_e, rd2_e        GRF rs / rt values
//   imm_sext, imm_zext  sign- / zero-extended imm16
//   fwd_m_data          forwarded M-stage ALU result
//   fwd_w_data          forwarded W-stage result
//   fwd_sel_a/b         0 GRF, 1 W, 2 M, 3 GRF
//   md_instr_d          MD-class instruction waiting in D
//   instr_out, pc_out, write_reg_out   passthroughs
//   rs_e, rt_e          register fields of instr_e
//   reg_write_e         instr_e writes the GRF
//   t_new_e             cycles until instr_e's result is available
//   alu_out             E result
//   write_data          forwarded rt (store data)
//   md_start            mult/multu/div/divu in E this cycle
//   md_busy             MD unit computing
//   stall_md            hold the MD-class instruction in D
//   hi_out, lo_out      HI / LO registers
module execute_md_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_e,
    input  logic [31:0] pc_e,
    input  logic [4:0]  write_reg_e,
    input  logic [31:0] rd1_e,
    input  logic [31:0] rd2_e,
    input  logic [31:0] imm_sext,
    input  logic [31:0] imm_zext,
    input  logic [31:0] fwd_m_data,
    input  logic [31:0] fwd_w_data,
    input  logic [1:0]  fwd_sel_a,
    input  logic [1:0]  fwd_sel_b,
    input  logic        md_instr_d,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [4:0]  write_reg_out,
    output logic [4:0]  rs_e,
    output logic [4:0]  rt_e,
    output logic        reg_write_e,
    output logic [1:0]  t_new_e,
    output logic [31:0] alu_out,
    output logic [31:0] write_data,
    output logic        md_start,
    output logic        md_busy,
    output logic        stall_md,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam int MAXC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAXC + 1);

    typedef enum logic [1:0] {
        MD_MULT,
        MD_MULTU,
        MD_DIV,
        MD_DIVU
    } md_kind_e;

    // ------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       is_r;

    assign opcode = instr_e[31:26];
    assign funct  = instr_e[5:0];
    assign is_r   = (opcode == 6'h00);

    logic op_addu, op_subu, op_and, op_or, op_slt, op_sltu;
    logic op_ori, op_lui, op_lw, op_sw, op_beq, op_jal;
    logic op_mult, op_multu, op_div, op_divu;
    logic op_mfhi, op_mflo, op_mthi, op_mtlo;

    assign op_addu  = is_r && (funct == 6'h21);
    assign op_subu  = is_r && (funct == 6'h23);
    assign op_and   = is_r && (funct == 6'h24);
    assign op_or    = is_r && (funct == 6'h25);
    assign op_slt   = is_r && (funct == 6'h2a);
    assign op_sltu  = is_r && (funct == 6'h2b);
    assign op_mult  = is_r && (funct == 6'h18);
    assign op_multu = is_r && (funct == 6'h19);
    assign op_div   = is_r && (funct == 6'h1a);
    assign op_divu  = is_r && (funct == 6'h1b);
    assign op_mfhi  = is_r && (funct == 6'h10);
    assign op_mthi  = is_r && (funct == 6'h11);
    assign op_mflo  = is_r && (funct == 6'h12);
    assign op_mtlo  = is_r && (funct == 6'h13);
    assign op_ori   = (opcode == 6'h0d);
    assign op_lui   = (opcode == 6'h0f);
    assign op_lw    = (opcode == 6'h23);
    assign op_sw    = (opcode == 6'h2b);
    assign op_beq   = (opcode == 6'h04);
    assign op_jal   = (opcode == 6'h03);

    // ------------------------------------------------------------
    // Passthroughs and hazard outputs
    // ------------------------------------------------------------
    assign instr_out     = instr_e;
    assign pc_out        = pc_e;
    assign write_reg_out = write_reg_e;
    assign rs_e          = instr_e[25:21];
    assign rt_e          = instr_e[20:16];

    assign reg_write_e = op_addu | op_subu | op_and | op_or
                       | op_slt | op_sltu | op_ori | op_lui
                       | op_lw | op_jal | op_mfhi | op_mflo;

    always_comb begin
        if (op_lw) begin
            t_new_e = 2'd2;
        end else if (reg_write_e) begin
            t_new_e = 2'd1;
        end else begin
            t_new_e = 2'd0;
        end
    end

    // ------------------------------------------------------------
    // Operand forwarding
    // ------------------------------------------------------------
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        case (fwd_sel_a)
            2'd1:    fwd_a = fwd_w_data;
            2'd2:    fwd_a = fwd_m_data;
            default: fwd_a = rd1_e;
        endcase
    end

    always_comb begin
        case (fwd_sel_b)
            2'd1:    fwd_b = fwd_w_data;
            2'd2:    fwd_b = fwd_m_data;
            default: fwd_b = rd2_e;
        endcase
    end

    always_comb begin
        op_a = fwd_a;
        if (op_ori) begin
            op_b = imm_zext;
        end else if (op_lw || op_sw) begin
            op_b = imm_sext;
        end else begin
            op_b = fwd_b;
        end
    end

    assign write_data = fwd_b;

    // ------------------------------------------------------------
    // ALU / result select
    // ------------------------------------------------------------
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    always_comb begin
        alu_out = op_a + op_b;
        unique case (1'b1)
            op_subu: alu_out = op_a - op_b;
            op_and:  alu_out = op_a & op_b;
            op_or:   alu_out = op_a | op_b;
            op_ori:  alu_out = op_a | op_b;
            op_slt:  alu_out = {31'd0, $signed(op_a) < $signed(op_b)};
            op_sltu: alu_out = {31'd0, op_a < op_b};
            op_lui:  alu_out = {instr_e[15:0], 16'd0};
            op_jal:  alu_out = pc_e + 32'd8;
            op_mfhi: alu_out = hi_q;
            op_mflo: alu_out = lo_q;
            default: alu_out = op_a + op_b;
        endcase
    end

    // ------------------------------------------------------------
    // Multiply / divide unit
    // ------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    md_kind_e      kind_q, kind_d;
    logic [31:0]   opa_q, opa_d;
    logic [31:0]   opb_q, opb_d;

    assign md_start = op_mult | op_multu | op_div | op_divu;
    assign md_busy  = (cnt_q != '0);
    assign stall_md = md_instr_d & (md_start | md_busy);
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;

    // Result is formed from the latched operands on the final
    // busy cycle and committed at that cycle's closing edge.
    logic               md_signed;
    logic               md_is_div;
    logic               div_zero;
    logic signed [63:0] ext_a;
    logic signed [63:0] ext_b;
    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        dvsr;
    logic [31:0]        q_u;
    logic [31:0]        r_u;
    logic [31:0]        quot;
    logic [31:0]        rem;
    logic [63:0]        md_res;

    always_comb begin
        md_signed = (kind_q == MD_MULT) || (kind_q == MD_DIV);
        md_is_div = (kind_q == MD_DIV) || (kind_q == MD_DIVU);
        div_zero  = (opb_q == 32'd0);

        ext_a  = {{32{opa_q[31]}}, opa_q};
        ext_b  = {{32{opb_q[31]}}, opb_q};
        prod_s = ext_a * ext_b;
        prod_u = {32'd0, opa_q} * {32'd0, opb_q};

        // Signed divide via magnitudes: avoids the overflowing
        // 0x80000000 / -1 case, which naturally yields 0x80000000.
        mag_a = (md_signed && opa_q[31]) ? (~opa_q + 32'd1) : opa_q;
        mag_b = (md_signed && opb_q[31]) ? (~opb_q + 32'd1) : opb_q;
        dvsr  = div_zero ? 32'd1 : mag_b;
        q_u   = mag_a / dvsr;
        r_u   = mag_a % dvsr;
        quot  = (md_signed && (opa_q[31] ^ opb_q[31]))
              ? (~q_u + 32'd1) : q_u;
        rem   = (md_signed && opa_q[31]) ? (~r_u + 32'd1) : r_u;

        unique case (kind_q)
            MD_MULT:  md_res = prod_s;
            MD_MULTU: md_res = prod_u;
            default:  md_res = {rem, quot};
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        kind_d = kind_q;
        opa_d  = opa_q;
        opb_d  = opb_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (md_start) begin
            cnt_d = (op_mult || op_multu)
                  ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            unique case (1'b1)
                op_mult:  kind_d = MD_MULT;
                op_multu: kind_d = MD_MULTU;
                op_div:   kind_d = MD_DIV;
                default:  kind_d = MD_DIVU;
            endcase
            opa_d = op_a;
            opb_d = fwd_b;
        end else if (md_busy) begin
            cnt_d = cnt_q - CW'(1);
            // Divide by zero keeps the busy time but drops the result.
            if (cnt_q == CW'(1) && !(md_is_div && div_zero)) begin
                hi_d = md_res[63:32];
                lo_d = md_res[31:0];
            end
        end

        if (op_mthi) begin
            hi_d = op_a;
        end
        if (op_mtlo) begin
            lo_d = op_a;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            kind_q <= MD_MULT;
            opa_q  <= 32'd0;
            opb_q  <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            kind_q <= kind_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

endmodule

// File: tb/tb_execute_md_stage.sv
// Self-checking bench for execute_md_stage: ALU paths, forwarding,
// MD timing/results, stall, mid-operation reset and HI/LO moves.
module tb_execute_md_stage;

    logic        clk;
    logic        reset;
    logic [31:0] instr_e, pc_e;
    logic [4:0]  write_reg_e;
    logic [31:0] rd1_e, rd2_e, imm_sext, imm_zext;
    logic [31:0] fwd_m_data, fwd_w_data;
    logic [1:0]  fwd_sel_a, fwd_sel_b;
    logic        md_instr_d;
    logic [31:0] instr_out, pc_out;
    logic [4:0]  write_reg_out, rs_e, rt_e;
    logic        reg_write_e;
    logic [1:0]  t_new_e;
    logic [31:0] alu_out, write_data;
    logic        md_start, md_busy, stall_md;
    logic [31:0] hi_out, lo_out;

    int n_cmp;
    int n_fail;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;

    execute_md_stage #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset),
        .instr_e(instr_e), .pc_e(pc_e), .write_reg_e(write_reg_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e),
        .imm_sext(imm_sext), .imm_zext(imm_zext),
        .fwd_m_data(fwd_m_data), .fwd_w_data(fwd_w_data),
        .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .md_instr_d(md_instr_d),
        .instr_out(instr_out), .pc_out(pc_out),
        .write_reg_out(write_reg_out), .rs_e(rs_e), .rt_e(rt_e),
        .reg_write_e(reg_write_e), .t_new_e(t_new_e),
        .alu_out(alu_out), .write_data(write_data),
        .md_start(md_start), .md_busy(md_busy), .stall_md(stall_md),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] r_op(input logic [5:0] f,
                                         input logic [4:0] rs,
                                         input logic [4:0] rt);
        return {6'd0, rs, rt, 5'd3, 5'd0, f};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op,
                                         input logic [4:0] rs,
                                         input logic [15:0] imm);
        return {op, rs, 5'd2, imm};
    endfunction

    // Stimulus only: starts an MD op in E, then bubbles until md_busy
    // drops (bounded), scrambling operands to exercise latching.
    task automatic md_op(input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic mdd,
                         output logic start_ok, output int busy_n,
                         output int stall_n, output logic stall_after);
        @(negedge clk);
        instr_e = ins; rd1_e = a; rd2_e = b;
        fwd_sel_a = 2'd0; fwd_sel_b = 2'd0; md_instr_d = mdd;
        #1;
        start_ok = (md_start === 1'b1) && (md_busy === 1'b0);
        stall_n = (stall_md === 1'b1) ? 1 : 0;
        busy_n = 0;
        @(negedge clk);
        instr_e = 32'd0; rd1_e = $urandom; rd2_e = $urandom;
        for (int k = 0; k < 64; k++) begin
            #1;
            if (md_busy !== 1'b1) break;
            busy_n++;
            if (stall_md === 1'b1) stall_n++;
            @(negedge clk);
            rd1_e = $urandom; rd2_e = $urandom;
        end
        stall_after = stall_md;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (hi_out !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi_out); end
        n_cmp++; if (lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo_out); end
        n_cmp++; if (md_busy !== 1'b0 || md_start !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b/%b want 0/0", md_busy, md_start); end
        n_cmp++; if (reg_write_e !== 1'b0 || t_new_e !== 2'd0) begin n_fail++; $display("FAIL reset_nop got %b/%0d want 0/0", reg_write_e, t_new_e); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_forward_alu;
        logic [31:0] ins_t[6], a_t[6], b_t[6], e_t[6];
        @(negedge clk);
        instr_e = r_op(6'h21, 5'd1, 5'd2); write_reg_e = 5'd3;
        rd1_e = 32'd5; fwd_sel_a = 2'd2; fwd_m_data = 32'd7;
        rd2_e = 32'd3; fwd_sel_b = 2'd0;
        sb_q.push_back(64'd10);
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0]) begin n_fail++; $display("FAIL addu_fwd_m got %h want %h", alu_out, exp_v[31:0]); end
        n_cmp++; if (write_data !== 32'd3 || rs_e !== 5'd1 || rt_e !== 5'd2) begin n_fail++; $display("FAIL addu_fields got %h/%0d/%0d want 3/1/2", write_data, rs_e, rt_e); end
        n_cmp++; if (reg_write_e !== 1'b1 || t_new_e !== 2'd1 || write_reg_out !== 5'd3) begin n_fail++; $display("FAIL addu_haz got %b/%0d/%0d want 1/1/3", reg_write_e, t_new_e, write_reg_out); end
        @(negedge clk);
        instr_e = r_op(6'h23, 5'd1, 5'd2);
        fwd_sel_b = 2'd1; fwd_w_data = 32'd9;
        sb_q.push_back(64'hFFFF_FFFE);
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0] || write_data !== 32'd9) begin n_fail++; $display("FAIL subu_fwd_w got %h/%h want %h/9", alu_out, write_data, exp_v[31:0]); end

        ins_t = '{r_op(6'h24, 1, 2), r_op(6'h25, 1, 2),
                  r_op(6'h2a, 1, 2), r_op(6'h2b, 1, 2),
                  r_op(6'h2a, 1, 2), r_op(6'h2b, 1, 2)};
        a_t = '{32'hF0F0_1234, 32'hF0F0_1234, 32'hFFFF_FFFF,
                32'hFFFF_FFFF, 32'd1, 32'd1};
        b_t = '{32'h0FF0_FFFF, 32'h0FF0_FFFF, 32'd1,
                32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e_t = '{32'h00F0_1234, 32'hFFF0_FFFF, 32'd1,
                32'd0, 32'd0, 32'd1};
        fwd_m_data = 32'hDEAD_BEEF; fwd_w_data = 32'hCAFE_F00D;
        fwd_sel_a = 2'd3; fwd_sel_b = 2'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr_e = ins_t[i]; rd1_e = a_t[i]; rd2_e = b_t[i];
            sb_q.push_back({32'd0, e_t[i]});
            #1; exp_v = sb_q.pop_front();
            n_cmp++; if (alu_out !== exp_v[31:0]) begin n_fail++; $display("FAIL alu_vec%0d got %h want %h", i, alu_out, exp_v[31:0]); end
        end
        fwd_sel_a = 2'd0; fwd_sel_b = 2'd0;
    endtask

    task automatic test_imm_ops;
        @(negedge clk);
        instr_e = i_op(6'h0d, 5'd1, 16'hFFFF);
        rd1_e = 32'h1234_0000; rd2_e = 32'h0;
        imm_zext = 32'h0000_FFFF; imm_sext = 32'hFFFF_FFFF;
        sb_q.push_back(64'h1234_FFFF);
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0] || reg_write_e !== 1'b1) begin n_fail++; $display("FAIL ori got %h/%b want %h/1", alu_out, reg_write_e, exp_v[31:0]); end
        @(negedge clk);
        instr_e = i_op(6'h0f, 5'd0, 16'hABCD);
        imm_zext = 32'h0000_ABCD; imm_sext = 32'hFFFF_ABCD;
        sb_q.push_back(64'hABCD_0000);
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0]) begin n_fail++; $display("FAIL lui got %h want %h", alu_out, exp_v[31:0]); end
        @(negedge clk);
        instr_e = {6'h03, 26'h0000C00}; pc_e = 32'h0000_3000;
        sb_q.push_back(64'h3008);
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0] || t_new_e !== 2'd1 || pc_out !== 32'h3000) begin n_fail++; $display("FAIL jal got %h/%0d want %h/1", alu_out, t_new_e, exp_v[31:0]); end
        @(negedge clk);
        instr_e = i_op(6'h23, 5'd1, 16'hFFFC);
        rd1_e = 32'h100; imm_sext = 32'hFFFF_FFFC; imm_zext = 32'hFFFC;
        sb_q.push_back(64'hFC);
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0] || t_new_e !== 2'd2) begin n_fail++; $display("FAIL lw got %h/%0d want %h/2", alu_out, t_new_e, exp_v[31:0]); end
        @(negedge clk);
        instr_e = i_op(6'h2b, 5'd1, 16'hFFFC); rd2_e = 32'h77;
        #1;
        n_cmp++; if (alu_out !== 32'hFC || reg_write_e !== 1'b0 || write_data !== 32'h77) begin n_fail++; $display("FAIL sw got %h/%b/%h want fc/0/77", alu_out, reg_write_e, write_data); end
        @(negedge clk);
        instr_e = 32'hFC00_0000;
        #1;
        n_cmp++; if (reg_write_e !== 1'b0 || md_start !== 1'b0 || t_new_e !== 2'd0) begin n_fail++; $display("FAIL nop_enc got %b/%b/%0d want 0/0/0", reg_write_e, md_start, t_new_e); end
    endtask

    task automatic test_mult_stall;
        logic s_ok, s_after;
        int b_n, s_n;
        md_op(r_op(6'h18, 1, 2), 32'hFFFF_FFFE, 32'd3, 1'b1,
              s_ok, b_n, s_n, s_after);
        sb_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFA});
        exp_v = sb_q.pop_front();
        n_cmp++; if (!s_ok || b_n != 5) begin n_fail++; $display("FAIL mult_timing got start %b busy %0d want 1/5", s_ok, b_n); end
        n_cmp++; if (s_n != 6 || s_after !== 1'b0) begin n_fail++; $display("FAIL mult_stall got %0d/%b want 6/0", s_n, s_after); end
        n_cmp++; if ({hi_out, lo_out} !== exp_v) begin n_fail++; $display("FAIL mult_res got %h want %h", {hi_out, lo_out}, exp_v); end
        md_op(r_op(6'h19, 1, 2), 32'hFFFF_FFFE, 32'd3, 1'b0,
              s_ok, b_n, s_n, s_after);
        sb_q.push_back({32'd2, 32'hFFFF_FFFA});
        exp_v = sb_q.pop_front();
        n_cmp++; if (b_n != 5 || s_n != 0 || s_after !== 1'b0) begin n_fail++; $display("FAIL multu_nostall got %0d/%0d want 5/0", b_n, s_n); end
        n_cmp++; if ({hi_out, lo_out} !== exp_v) begin n_fail++; $display("FAIL multu_res got %h want %h", {hi_out, lo_out}, exp_v); end
    endtask

    task automatic test_div;
        logic s_ok, s_after;
        int b_n, s_n;
        logic [31:0] a_t[4], b_t[4], f_t[4];
        logic [63:0] e_t[4];
        f_t = '{32'h1a, 32'h1b, 32'h1a, 32'h1b};
        a_t = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd100};
        b_t = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'd7};
        e_t = '{{32'hFFFF_FFFF, 32'hFFFF_FFFD},
                {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                {32'h0, 32'h8000_0000},
                {32'd2, 32'd14}};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(e_t[i]);
            md_op(r_op(f_t[i][5:0], 1, 2), a_t[i], b_t[i], 1'b0,
                  s_ok, b_n, s_n, s_after);
            exp_v = sb_q.pop_front();
            n_cmp++; if (!s_ok || b_n != 10) begin n_fail++; $display("FAIL div%0d_timing got start %b busy %0d want 1/10", i, s_ok, b_n); end
            n_cmp++; if ({hi_out, lo_out} !== exp_v) begin n_fail++; $display("FAIL div%0d_res got %h want %h", i, {hi_out, lo_out}, exp_v); end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        instr_e = r_op(6'h1a, 1, 2); rd1_e = 32'd100; rd2_e = 32'd7;
        repeat (2) begin
            @(negedge clk);
            instr_e = 32'd0;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (md_busy !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_mid got %b/%h/%h want 0/0/0", md_busy, hi_out, lo_out); end
        repeat (12) @(negedge clk);
        #1;
        n_cmp++; if (hi_out !== 32'd0 || lo_out !== 32'd0) begin n_fail++; $display("FAIL reset_discard got %h/%h want 0/0", hi_out, lo_out); end
    endtask

    task automatic test_mthi_mtlo;
        @(negedge clk);
        instr_e = r_op(6'h11, 5'd4, 5'd0); rd1_e = 32'h55;
        sb_q.push_back(64'h55);
        @(negedge clk);
        instr_e = r_op(6'h12 - 6'h2, 5'd0, 5'd0); rd1_e = 32'h0;
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0] || reg_write_e !== 1'b1) begin n_fail++; $display("FAIL mthi_mfhi got %h/%b want %h/1", alu_out, reg_write_e, exp_v[31:0]); end
        @(negedge clk);
        instr_e = r_op(6'h13, 5'd4, 5'd0); rd1_e = 32'hAA;
        sb_q.push_back({32'h55, 32'hAA});
        @(negedge clk);
        instr_e = r_op(6'h12, 5'd0, 5'd0); rd1_e = 32'h0;
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0] || hi_out !== exp_v[63:32]) begin n_fail++; $display("FAIL mtlo_mflo got %h/%h want %h", alu_out, hi_out, exp_v); end
    endtask

    task automatic test_back_to_back;
        logic s_ok, s_after;
        int b_n, s_n;
        sb_q.push_back(64'd42);
        md_op(r_op(6'h18, 1, 2), 32'd6, 32'd7, 1'b1,
              s_ok, b_n, s_n, s_after);
        instr_e = r_op(6'h12, 5'd0, 5'd0);
        #1; exp_v = sb_q.pop_front();
        n_cmp++; if (alu_out !== exp_v[31:0] || b_n != 5) begin n_fail++; $display("FAIL mflo_next got %h/%0d want %h/5", alu_out, b_n, exp_v[31:0]); end
        @(negedge clk);
        instr_e = 32'd0; md_instr_d = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        reset = 1'b1;
        instr_e = 32'd0; pc_e = 32'd0; write_reg_e = 5'd0;
        rd1_e = 32'd0; rd2_e = 32'd0;
        imm_sext = 32'd0; imm_zext = 32'd0;
        fwd_m_data = 32'd0; fwd_w_data = 32'd0;
        fwd_sel_a = 2'd0; fwd_sel_b = 2'd0; md_instr_d = 1'b0;
        test_reset();
        test_forward_alu();
        test_imm_ops();
        test_mult_stall();
        test_div();
        test_reset_mid();
        test_mthi_mtlo();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_md_stage.md
Name: execute_md_stage

Overview:
- Pipeline E stage for the five-stage MIPS core; successor of the single-cycle-ALU execute stage.
- Adds a parametrised multi-cycle multiply/divide unit with HI/LO registers, mult/div busy tracking and a D-stage stall request.
- Keeps operand forwarding selection, ALU, lui/jal result selection and the E-stage hazard outputs (Tnew, rs/rt, reg write).
- Sits between the D/E and E/M pipeline registers, which remain external; E never stalls, and a bubble is instr 0.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu start (>=1)
DIV_CYCLES, 10, busy cycles after a div/divu start (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
instr_e  in  32  instruction in E
pc_e  in  32  PC of instr_e
write_reg_e  in  5  destination register from D
rd1_e  in  32  GRF rs value
rd2_e  in  32  GRF rt value
imm_sext  in  32  sign-extended imm16
imm_zext  in  32  zero-extended imm16
fwd_m_data  in  32  forwarded M-stage ALU result
fwd_w_data  in  32  forwarded W-stage result
fwd_sel_a  in  2  rs source: 0 rd1, 1 W, 2 M, 3 treated as 0
fwd_sel_b  in  2  rt source, same encoding
md_instr_d  in  1  instruction in D is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
instr_out  out  32  instr_e passthrough
pc_out  out  32  pc_e passthrough
write_reg_out  out  5  write_reg_e passthrough
rs_e  out  5  instr_e[25:21]
rt_e  out  5  instr_e[20:16]
reg_write_e  out  1  instr_e writes GRF
t_new_e  out  2  Tnew at E
alu_out  out  32  E result
write_data  out  32  forwarded rt, used as sw data
md_start  out  1  mult/multu/div/divu in E this cycle
md_busy  out  1  MD unit computing
stall_md  out  1  md_instr_d & (md_start | md_busy)
hi_out  out  32  HI register
lo_out  out  32  LO register

Behaviour:
- Decode: addu, subu, and, or, slt, sltu, ori, lui, lw, sw, beq, jal, mult, multu, div, divu, mfhi, mflo, mthi, mtlo. Any other encoding is a nop: no write, no MD effect.
- Operand A is the forwarded rs. Operand B is imm_zext for ori, imm_sext for lw/sw, otherwise the forwarded rt.
- alu_out by instruction:
  - R-type ALU ops on A,B; slt is signed, sltu unsigned.
  - lui: {imm16,16'b0}.
  - jal: pc_e+8.
  - lw/sw: A+imm_sext.
  - mfhi: HI; mflo: LO.
  - All other instructions: A+B. This path is purely combinational.
- reg_write_e = 1 for ALU ops, ori, lui, lw, jal, mfhi, mflo; otherwise 0.
- t_new_e = 2 for lw; 1 for other writers; 0 for non-writers.
- MD timing:
  - md_start is combinational and high in cycle t while a mult/div op is in E.
  - An internal counter loads MULT_CYCLES or DIV_CYCLES at the edge ending t. md_busy is high during cycles t+1..t+N.
  - HI/LO are written at the edge ending t+N; md_busy is low from t+N+1.
- MD results:
  - mult: signed 64-bit product. multu: unsigned product. HI holds the upper 32 bits, LO the lower 32 bits.
  - div: LO is the quotient truncated toward zero, HI is the remainder with the dividend's sign. divu: unsigned.
  - Division by zero: still busy for DIV_CYCLES; HI/LO are left unchanged.
  - 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Operands are latched at md_start, so later changes to rd1/rd2/forwarding have no effect.
- mthi/mtlo write HI/LO from forwarded rs at the edge ending their E cycle. They never start the counter.
- stall_md keeps any MD-class instruction in D until HI/LO are final. Consequently no mthi/mtlo/mfhi/mflo/start can be in E while md_busy is high. An mfhi entering E at t+N+1 reads the new value.
- Reset (synchronous, any time including mid-operation): HI=0, LO=0, counter=0, md_busy=0, pending result discarded. Combinational outputs follow the inputs.

Test Plan:
- rd1=5, fwd_sel_a=2, fwd_m_data=7, rd2=3, addu -> alu_out=10; fwd_sel_b=1, fwd_w_data=9, subu -> alu_out=0xFFFFFFFE (7-9).
- ori imm 0xFFFF with rs=0x12340000 -> 0x1234FFFF; lui 0xABCD -> 0xABCD0000; jal at pc 0x3000 -> 0x3008, t_new_e=1.
- mult A=0xFFFFFFFE, B=3, MULT_CYCLES=5 -> md_start for 1 cycle, md_busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=2, LO=0xFFFFFFFA.
- div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after DIV_CYCLES; divu 7/0 -> busy 10 cycles, HI/LO unchanged.
- md_instr_d=1 during md_start and all busy cycles -> stall_md=1 each cycle, 0 from t+N+1; md_instr_d=0 -> stall_md=0 throughout.
- reset at cycle 3 of a div -> md_busy=0 next cycle, HI=LO=0, no later HI/LO update; mthi 0x55 then mfhi -> alu_out=0x55.
